// File: rtl/seg_page_sequencer.sv
// Pages a captured 144-bit word onto a six-digit hex display, 24 bits per page.
// Supports a timed auto-sweep, manual step, hold, repeat and a valid/ready capture.
module seg_page_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid,
  input  logic [143:0] data_in,
  output logic         data_ready,
  input  logic         auto_en,
  input  logic         hold,
  input  logic         repeat_en,
  input  logic         step,
  output logic [23:0]  disp_value,
  output logic [2:0]   page_idx,
  output logic         page_valid,
  output logic         sweep_done
);

  localparam int unsigned TW = $clog2(DWELL_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t         state, state_n;
  logic [143:0]   word, word_n;
  logic [TW-1:0]  timer, timer_n;
  logic [2:0]     page_n;
  logic           done_n;
  logic           step_q, step_rise;
  logic           capture, expire;
  logic [23:0]    slice_n;

  assign data_ready = (state != SHOW) | repeat_en;
  assign capture    = data_valid & data_ready;
  assign expire     = (state == SHOW) & auto_en & ~hold & (timer == T_LAST);

  // Capture outranks any advance; a step and an expiry together still advance once.
  always_comb begin
    state_n = state;
    word_n  = word;
    page_n  = page_idx;
    timer_n = timer;
    done_n  = 1'b0;
    if (capture) begin
      word_n  = data_in;
      page_n  = 3'd0;
      timer_n = '0;
      state_n = SHOW;
    end else if (state == SHOW) begin
      if (step_rise | expire) begin
        timer_n = '0;
        if (page_idx == 3'd5) begin
          done_n = 1'b1;
          if (repeat_en) page_n  = 3'd0;
          else           state_n = DONE;
        end else begin
          page_n = page_idx + 3'd1;
        end
      end else if (auto_en & ~hold) begin
        timer_n = timer + TW'(1);
      end
    end
  end

  always_comb begin
    case (page_n)
      3'd0:    slice_n = word_n[143:120];
      3'd1:    slice_n = word_n[119:96];
      3'd2:    slice_n = word_n[95:72];
      3'd3:    slice_n = word_n[71:48];
      3'd4:    slice_n = word_n[47:24];
      default: slice_n = word_n[23:0];
    endcase
  end

  // The step edge is registered, so a sampled rising edge moves the page one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      timer      <= '0;
      disp_value <= '0;
      page_idx   <= '0;
      page_valid <= 1'b0;
      sweep_done <= 1'b0;
      step_q     <= 1'b0;
      step_rise  <= 1'b0;
    end else begin
      state      <= state_n;
      word       <= word_n;
      timer      <= timer_n;
      disp_value <= slice_n;
      page_idx   <= page_n;
      page_valid <= page_valid | capture;
      sweep_done <= done_n;
      step_q     <= step;
      step_rise  <= step & ~step_q;
    end
  end

endmodule

// File: tb/tb_seg_page_sequencer.sv
// Directed and random checks of seg_page_sequencer against a cycle-level
// reference model of paging, dwell, step, hold, repeat and capture rules.
module tb_seg_page_sequencer;

  localparam int unsigned DWELL = 4;
  localparam logic [143:0] W1 = 144'h0123456789abcdef0123456789abcdef0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid = 1'b0;
  logic [143:0] data_in = '0;
  logic         auto_en = 1'b0;
  logic         hold = 1'b0;
  logic         repeat_en = 1'b0;
  logic         step = 1'b0;
  logic         data_ready;
  logic [23:0]  disp_value;
  logic [2:0]   page_idx;
  logic         page_valid;
  logic         sweep_done;

  seg_page_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .data_ready(data_ready), .auto_en(auto_en), .hold(hold),
    .repeat_en(repeat_en), .step(step), .disp_value(disp_value),
    .page_idx(page_idx), .page_valid(page_valid), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = nothing captured, 1 = sweeping, 2 = parked on last page.
  logic [143:0] m_word;
  int           m_page, m_cnt, m_mode;
  bit           m_valid, m_done, m_prev, m_pend;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_word = '0; m_page = 0; m_cnt = 0; m_mode = 0;
    m_valid = 0; m_done = 0; m_prev = 0; m_pend = 0;
  endtask

  function automatic logic [23:0] m_disp();
    logic [143:0] sh;
    sh = m_word >> (24 * (5 - m_page));
    return sh[23:0];
  endfunction

  task automatic compare_all();
    check("disp_value", {120'd0, disp_value}, {120'd0, m_disp()});
    check("page_idx", {141'd0, page_idx}, 144'(m_page));
    check("page_valid", {143'd0, page_valid}, {143'd0, m_valid});
    check("sweep_done", {143'd0, sweep_done}, {143'd0, m_done});
    check("data_ready", {143'd0, data_ready}, {143'd0, (m_mode != 1) || repeat_en});
  endtask

  task automatic cycle();
    logic [143:0] nw;
    int np, nc, nm;
    bit nv, nd, cap, exp_, npend;
    nw = m_word; np = m_page; nc = m_cnt; nm = m_mode; nv = m_valid; nd = 0;
    cap  = data_valid && ((m_mode != 1) || repeat_en);
    exp_ = (m_mode == 1) && auto_en && !hold && (m_cnt == DWELL - 1);
    npend = step && !m_prev;
    if (cap) begin
      nw = data_in; np = 0; nc = 0; nm = 1; nv = 1;
    end else if (m_mode == 1 && (m_pend || exp_)) begin
      nc = 0;
      if (m_page == 5) begin
        nd = 1;
        if (repeat_en) np = 0; else nm = 2;
      end else np = m_page + 1;
    end else if (m_mode == 1 && auto_en && !hold) begin
      nc = m_cnt + 1;
    end
    @(posedge clk);
    if (reset) m_reset();
    else begin
      m_word = nw; m_page = np; m_cnt = nc; m_mode = nm; m_valid = nv;
      m_done = nd; m_prev = step; m_pend = npend;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_page(input int p, input int budget);
    for (int i = 0; i < budget && int'(page_idx) != p; i++) cycle();
    check("wait_page", {141'd0, page_idx}, 144'(p));
  endtask

  task automatic capture_word(input logic [143:0] w);
    repeat_en = 1'b1; data_valid = 1'b1; data_in = w;
    cycle();
    data_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [159:0] r;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_disp", {120'd0, disp_value}, '0);
    check("rst_page", {141'd0, page_idx}, '0);
    check("rst_valid", {143'd0, page_valid}, '0);
    check("rst_done", {143'd0, sweep_done}, '0);
    check("rst_ready", {143'd0, data_ready}, 144'd1);
    reset = 1'b0;
    run(3);

    // Single non-repeating auto sweep
    auto_en = 1'b1; repeat_en = 1'b0; data_valid = 1'b1; data_in = W1;
    cycle();
    data_valid = 1'b0;
    check("t1_first", {120'd0, disp_value}, 144'h012345);
    n = 0;
    for (int i = 0; i < 30; i++) begin cycle(); n += int'(sweep_done); end
    check("t1_sweeps", 144'(n), 144'd1);
    check("t1_last", {120'd0, disp_value}, 144'hef0000);
    check("t1_ready", {143'd0, data_ready}, 144'd1);

    // Repeating sweep: a pulse every 6*DWELL cycles
    repeat_en = 1'b1; data_valid = 1'b1;
    cycle();
    data_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin cycle(); n += int'(sweep_done); end
    check("t2_sweeps", 144'(n), 144'd2);

    // Manual stepping
    auto_en = 1'b0;
    capture_word(W1);
    repeat_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle();
      check("t3_step", {141'd0, page_idx}, 144'(k));
      cycle();
    end
    step = 1'b1; run(10);
    step = 1'b0; run(2);
    check("t3_held", {141'd0, page_idx}, 144'd4);

    // Hold on page 1
    auto_en = 1'b1;
    capture_word(W1);
    repeat_en = 1'b0;
    wait_page(1, 20);
    n = 1;
    cycle(); n += int'(page_idx == 3'd1);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) begin cycle(); n += int'(page_idx == 3'd1); end
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin cycle(); n += int'(page_idx == 3'd1); end
    check("t4_hold_len", 144'(n), 144'd11);

    // Step coinciding with expiry, then capture alongside a step
    capture_word(W1);
    repeat_en = 1'b0;
    wait_page(2, 20);
    run(2);
    step = 1'b1; cycle();
    step = 1'b0; cycle();
    check("t5_collide", {141'd0, page_idx}, 144'd3);
    repeat_en = 1'b1;
    step = 1'b1; cycle();
    step = 1'b0; data_valid = 1'b1; data_in = ~W1;
    cycle();
    data_valid = 1'b0;
    check("t5_capture", {120'd0, disp_value}, 144'hfedcba);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      data_in    = r[143:0];
      data_valid = ($urandom_range(0, 19) == 0);
      auto_en    = ($urandom_range(0, 4) != 0);
      hold       = ($urandom_range(0, 4) == 0);
      repeat_en  = ($urandom_range(0, 1) == 0);
      step       = ($urandom_range(0, 2) == 0);
      cycle();
    end
    data_valid = 1'b0; hold = 1'b0; step = 1'b0;

    // Asynchronous reset mid page 4
    auto_en = 1'b1;
    capture_word(W1);
    repeat_en = 1'b0;
    wait_page(4, 40);
    cycle();
    #2 reset = 1'b1;
    #1;
    check("ar_disp", {120'd0, disp_value}, '0);
    check("ar_page", {141'd0, page_idx}, '0);
    check("ar_valid", {143'd0, page_valid}, '0);
    check("ar_ready", {143'd0, data_ready}, 144'd1);
    m_reset();
    @(negedge clk);
    run(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin step = i[1]; cycle(); end
    check("ar_idle", {141'd0, page_idx}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
